bus_mem_ctrl: RTL



---
 rtl/bus_mem_ctrl_pkg.sv | 26 ++
 rtl/bus_mem_ctrl_uart_tx_fifo.sv | 79 +++++++
 rtl/bus_mem_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/bus_mem_ctrl_pkg.sv
// Shared address map, STATUS layout and state encodings for the bus memory controller.
package bus_map_pkg;

  localparam logic [31:0] TXDATA_ADDR = 32'h8000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;

  localparam int unsigned ST_FULL_BIT  = 0;
  localparam int unsigned ST_EMPTY_BIT = 1;
  localparam int unsigned ST_BUSY_BIT  = 2;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_RAM,
    SRC_STATUS
  } rd_src_e;

endpackage

// File: rtl/bus_mem_ctrl_uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: circular byte FIFO feeding a bit-timed shifter.
module uart_tx_fifo
  import bus_map_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       uart_tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic [CW-1:0] clk_cnt_q;
  logic [3:0]    bits_left_q;
  logic [8:0]    shift_q;
  logic          busy_q, tx_q;
  logic          bit_end, frame_end, pop;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign bit_end   = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign frame_end = busy_q && bit_end && (bits_left_q == '0);
  // Popping on the last stop-bit cycle lets the next start bit follow with no idle gap.
  assign pop       = (!busy_q || frame_end) && !empty;

  assign busy    = busy_q;
  assign uart_tx = tx_q;

  always_ff @(posedge clk) begin
    if (push && !full) fifo_mem[wptr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      clk_cnt_q   <= '0;
      bits_left_q <= '0;
      shift_q     <= '1;
      busy_q      <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      if (push && !full) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q      <= rptr_q + 1'b1;
        busy_q      <= 1'b1;
        tx_q        <= 1'b0;
        shift_q     <= {1'b1, fifo_mem[rptr_q[AW-1:0]]};
        bits_left_q <= 4'(UART_DATA_BITS + 1);
        clk_cnt_q   <= '0;
      end else if (busy_q) begin
        if (!bit_end) begin
          clk_cnt_q <= clk_cnt_q + 1'b1;
        end else begin
          clk_cnt_q <= '0;
          if (bits_left_q == '0) begin
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
          end else begin
            tx_q        <= shift_q[0];
            shift_q     <= {1'b1, shift_q[8:1]};
            bits_left_q <= bits_left_q - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/bus_mem_ctrl.sv
// Bus slave terminating CPU fetch/load/store: byte-masked word RAM plus MMIO UART,
// fixed two-cycle strobe-to-done latency, HOLD back-pressure on a full UART FIFO.
module bus_mem_ctrl
  import bus_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS    = 4096,
  parameter string       INIT_FILE    = "",
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wmask,
  input  logic        bus_wen,
  input  logic        bus_ren,
  output logic [31:0] bus_rdata,
  output logic        bus_done,
  output logic        uart_tx
);

  localparam int unsigned RAW = $clog2(RAM_WORDS);

  state_e      state_q;
  rd_src_e     rd_src_q;
  logic [31:0] bus_rdata_q, ram_rd_q, status_word;
  logic        done_q;
  logic [31:0] ram_mem [RAM_WORDS];
  logic [RAW-1:0] ram_idx;
  logic        idle, ram_hit, tx_hit, st_hit, ram_we, ram_re, push;
  logic        fifo_full, fifo_empty, tx_busy;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus_addr[1:0];

  assign idle    = (state_q == S_IDLE);
  assign ram_hit = !bus_addr[31];
  assign tx_hit  = (bus_addr[31:2] == TXDATA_ADDR[31:2]);
  assign st_hit  = (bus_addr[31:2] == STATUS_ADDR[31:2]);
  assign ram_idx = bus_addr[RAW+1:2];
  assign ram_we  = idle && bus_wen && ram_hit;
  assign ram_re  = idle && !bus_wen && bus_ren && ram_hit;
  // HOLD relies on the master holding wen/addr/wdata until done.
  assign push    = ((idle && bus_wen && tx_hit) || (state_q == S_HOLD)) && !fifo_full;

  always_comb begin
    status_word               = '0;
    status_word[ST_FULL_BIT]  = fifo_full;
    status_word[ST_EMPTY_BIT] = fifo_empty;
    status_word[ST_BUSY_BIT]  = tx_busy;
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus_wmask[b]) ram_mem[ram_idx][8*b +: 8] <= bus_wdata[8*b +: 8];
      end
    end
    if (ram_re) ram_rd_q <= ram_mem[ram_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_src_q    <= SRC_ZERO;
      bus_rdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus_wen) begin
            rd_src_q <= SRC_ZERO;
            state_q  <= (tx_hit && fifo_full) ? S_HOLD : S_WAIT;
          end else if (bus_ren) begin
            rd_src_q <= ram_hit ? SRC_RAM : (st_hit ? SRC_STATUS : SRC_ZERO);
            state_q  <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (!fifo_full) state_q <= S_WAIT;
        end
        S_WAIT: begin
          case (rd_src_q)
            SRC_RAM:    bus_rdata_q <= ram_rd_q;
            SRC_STATUS: bus_rdata_q <= status_word;
            default:    bus_rdata_q <= '0;
          endcase
          done_q  <= 1'b1;
          state_q <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_rdata = bus_rdata_q;
  assign bus_done  = done_q;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_uart (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(bus_wdata[7:0]),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .busy     (tx_busy),
    .uart_tx  (uart_tx)
  );

endmodule
